// File: rtl/uart_pkg.sv
// Shared UART constants and types.
//   UART_DATA_W         : bits per received character
//   UART_RX_FIFO_DEPTH  : default receive FIFO depth
//   uart_char_t         : one received character
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_char_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// Handshake and status bundle between the UART receive FIFO and its users.
//   master : receiver/consumer side (drives wr_en, wr_data, rd_en)
//   slave  : FIFO side (drives rd_data, rd_valid, flags, level, pulses)
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, fifo_full, fifo_empty, level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, fifo_full, fifo_empty, level, overflow, underflow
  );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
//   clk, rst         : clock, synchronous active-high reset (read register only)
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request; rd_data updates on the next edge and
//                      holds otherwise. Storage itself is never cleared.
module uart_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers deserialized characters for the consumer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of uart_rx_fifo_if (write/read requests in;
//              read data, valid pulse, full/empty/level, overflow/underflow out)
// All outputs are registered; full/empty come from the occupancy count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             wr_acc_c;
  logic             rd_acc_c;
  logic [LVL_W-1:0] level_nxt_c;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    wr_acc_c    = bus.wr_en && (!bus.fifo_full || bus.rd_en);
    rd_acc_c    = bus.rd_en && !bus.fifo_empty;
    level_nxt_c = level_q;
    case ({wr_acc_c, rd_acc_c})
      2'b10:   level_nxt_c = level_q + LVL_W'(1);
      2'b01:   level_nxt_c = level_q - LVL_W'(1);
      default: level_nxt_c = level_q;
    endcase
  end

  // Pointers, occupancy, flags and diagnostic pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_q        <= '0;
      bus.fifo_full  <= 1'b0;
      bus.fifo_empty <= 1'b1;
      bus.rd_valid   <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.underflow  <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc_c) rd_ptr <= rd_ptr + PTR_W'(1);
      level_q        <= level_nxt_c;
      bus.fifo_full  <= (level_nxt_c == LVL_W'(DEPTH));
      bus.fifo_empty <= (level_nxt_c == '0);
      bus.rd_valid   <= rd_acc_c;
      bus.overflow   <= bus.wr_en && bus.fifo_full && !bus.rd_en;
      bus.underflow  <= bus.rd_en && bus.fifo_empty;
    end
  end

  assign bus.level = level_q;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc_c),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_acc_c),
    .rd_addr (rd_ptr),
    .rd_data (bus.rd_data)
  );

endmodule : uart_rx_fifo
